// File: rtl/locker_supervisor_if.sv
// Keypad and locker-core signal bundle for locker_supervisor.
//   kp_key_in / kp_key_valid / kp_enter : keypad digit, digit strobe, enter strobe
//   core_key_in / core_key_valid        : digit forwarded to the locker core
//   core_enter                          : enter strobe forwarded to the locker core
//   core_reset                          : one-cycle re-arm pulse to the locker core
//   core_open / core_error              : core verdict (code correct / code wrong)
// slave  = supervisor view, master = keypad/core environment view.
interface locker_supervisor_if;
  logic [3:0] kp_key_in;
  logic       kp_key_valid;
  logic       kp_enter;
  logic [3:0] core_key_in;
  logic       core_key_valid;
  logic       core_enter;
  logic       core_reset;
  logic       core_open;
  logic       core_error;

  modport slave (
    input  kp_key_in, kp_key_valid, kp_enter, core_open, core_error,
    output core_key_in, core_key_valid, core_enter, core_reset
  );

  modport master (
    output kp_key_in, kp_key_valid, kp_enter, core_open, core_error,
    input  core_key_in, core_key_valid, core_enter, core_reset
  );
endinterface

// File: rtl/locker_supervisor.sv
// Locker supervisor: forwards keypad strobes to the locker core, waits for the
// core's verdict, drives the door actuator, counts consecutive failures and
// imposes a timed keypad lockout. The core is re-armed after every verdict.
// Ports:
//   clk        : system clock, posedge
//   reset      : synchronous, active-high
//   bus        : keypad / core signals (locker_supervisor_if.slave)
//   unlock     : door actuator, high OPEN_CYCLES cycles after a correct code
//   lockout    : high while the keypad is blocked
//   alarm      : one-cycle pulse on lockout entry
//   fail_count : consecutive failures, saturating at MAX_FAIL
//
// state      | meaning
// S_ARMED    | forwarding keys, waiting for enter
// S_WAIT     | enter sent, waiting for core verdict or timeout
// S_UNLOCKED | door open for OPEN_CYCLES
// S_LOCKOUT  | keypad blocked for LOCKOUT_CYCLES
// S_RELOCK   | core_reset high for one cycle, then back to armed
module locker_supervisor #(
  parameter int MAX_FAIL       = 3,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int RESULT_TIMEOUT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  locker_supervisor_if.slave                bus,
  output logic                              unlock,
  output logic                              lockout,
  output logic                              alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);

  localparam int FCW  = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                        ((OPEN_CYCLES > RESULT_TIMEOUT) ? OPEN_CYCLES : RESULT_TIMEOUT) :
                        ((LOCKOUT_CYCLES > RESULT_TIMEOUT) ? LOCKOUT_CYCLES : RESULT_TIMEOUT);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_ARMED,
    S_WAIT,
    S_UNLOCKED,
    S_LOCKOUT,
    S_RELOCK
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [FCW-1:0]   fc_q, fc_n, fc_inc;
  logic [3:0]       key_q, key_n;
  logic             kv_q, kv_n;
  logic             en_q, en_n;
  logic             crst_q, crst_n;
  logic             unlock_q, unlock_n;
  logic             lockout_q, lockout_n;
  logic             alarm_q, alarm_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_ARMED;
      timer     <= '0;
      fc_q      <= '0;
      key_q     <= '0;
      kv_q      <= 1'b0;
      en_q      <= 1'b0;
      crst_q    <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      fc_q      <= fc_n;
      key_q     <= key_n;
      kv_q      <= kv_n;
      en_q      <= en_n;
      crst_q    <= crst_n;
      unlock_q  <= unlock_n;
      lockout_q <= lockout_n;
      alarm_q   <= alarm_n;
    end
  end

  // Saturating increment; lockout clears the count before it could exceed MAX_FAIL.
  assign fc_inc = (fc_q == FCW'(MAX_FAIL)) ? fc_q : fc_q + FCW'(1);

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    fc_n      = fc_q;
    key_n     = key_q;
    kv_n      = 1'b0;
    en_n      = 1'b0;
    crst_n    = 1'b0;
    unlock_n  = 1'b0;
    lockout_n = 1'b0;
    alarm_n   = 1'b0;
    case (state)
      S_ARMED: begin
        // A key strobe takes priority; a simultaneous enter is dropped.
        if (bus.kp_key_valid) begin
          kv_n  = 1'b1;
          key_n = bus.kp_key_in;
        end else if (bus.kp_enter) begin
          en_n    = 1'b1;
          state_n = S_WAIT;
          timer_n = '0;
        end
      end
      S_WAIT: begin
        // core_error wins over core_open; silence until the last slot is a failure.
        if (bus.core_error ||
            (!bus.core_open && timer == TW'(RESULT_TIMEOUT - 1))) begin
          fc_n = fc_inc;
          if (fc_inc == FCW'(MAX_FAIL)) begin
            state_n   = S_LOCKOUT;
            lockout_n = 1'b1;
            alarm_n   = 1'b1;
            timer_n   = '0;
          end else begin
            state_n = S_RELOCK;
            crst_n  = 1'b1;
          end
        end else if (bus.core_open) begin
          state_n  = S_UNLOCKED;
          unlock_n = 1'b1;
          fc_n     = '0;
          timer_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_UNLOCKED: begin
        if (timer == TW'(OPEN_CYCLES - 1)) begin
          state_n = S_RELOCK;
          crst_n  = 1'b1;
        end else begin
          unlock_n = 1'b1;
          timer_n  = timer + TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
          state_n = S_RELOCK;
          crst_n  = 1'b1;
          fc_n    = '0;
        end else begin
          lockout_n = 1'b1;
          timer_n   = timer + TW'(1);
        end
      end
      S_RELOCK: begin
        state_n = S_ARMED;
      end
      default: begin
        state_n = S_ARMED;
      end
    endcase
  end

  assign bus.core_key_in    = key_q;
  assign bus.core_key_valid = kv_q;
  assign bus.core_enter     = en_q;
  assign bus.core_reset     = crst_q;
  assign unlock             = unlock_q;
  assign lockout            = lockout_q;
  assign alarm              = alarm_q;
  assign fail_count         = fc_q;

endmodule
